// File: rtl/ddr_pkg.sv
// Shared types and timing constants for the DDR init-sequence responder.
// INIT_ORDER_CHECK_EN (used in dram_init_resp) enables strict MRS ordering against MR_SEQ.
package ddr_pkg;

  localparam int unsigned tXPR = 10;
  localparam int unsigned tMRD = 8;
  localparam int unsigned tMOD = 12;
  localparam int unsigned tZQ  = 20;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned GAP_MAX = max_u(max_u(tXPR, tMRD), max_u(tMOD, tZQ));
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

  typedef enum logic [2:0] {
    S_RST, S_XPR, S_MRS, S_MOD, S_ZQ, S_DONE, S_ERR
  } state_e;

  typedef enum logic [1:0] {
    CMD_DES, CMD_MRS, CMD_ZQCL, CMD_OTHER
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_XPR      = 3'd1,
    ERR_MRD      = 3'd2,
    ERR_SEQ      = 3'd3,
    ERR_MOD      = 3'd4,
    ERR_ILLEGAL  = 3'd5,
    ERR_CKE_DROP = 3'd6
  } err_e;

  // Required JEDEC MRS order, first entry issued first.
  localparam logic [2:0] MR_SEQ [7] = '{3'd3, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};

  // CKE low means the command pins are not sampled, which is the same as a deselect.
  function automatic cmd_e decode_cmd(input logic cke, input logic cs_n, input logic act_n,
                                      input logic ras_n, input logic cas_n, input logic we_n,
                                      input logic a10);
    if (!cke || cs_n)                                 return CMD_DES;
    if (act_n && !ras_n && !cas_n && !we_n)           return CMD_MRS;
    if (act_n && ras_n && cas_n && !we_n && a10)      return CMD_ZQCL;
    return CMD_OTHER;
  endfunction

endpackage

// File: rtl/init_gap_cnt.sv
// Cycles-since-last-event counter: clears on request, otherwise counts up and saturates.
module init_gap_cnt
  import ddr_pkg::*;
#(
  parameter int unsigned W = GAP_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)             cnt_d = '0;
    else if (cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers take non-blocking (<=) assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dram_init_resp.sv
// DDR4 device-side model that checks the controller's power-up init sequence and decodes MRs.
// Define INIT_ORDER_CHECK_EN to require MRS order MR3,MR6,MR5,MR4,MR2,MR1,MR0 with no repeats.
module dram_init_resp
  import ddr_pkg::*;
(
  input  logic        CK_t,
  input  logic        reset_n,
  input  logic        CKE,
  input  logic        CS_n,
  input  logic        ACT_n,
  input  logic        RAS_n,
  input  logic        CAS_n,
  input  logic        WE_n,
  input  logic [2:0]  BG0_BA,
  input  logic [13:0] A,
  output logic        init_done,
  output logic        mr_wr,
  output logic [2:0]  mr_sel,
  output logic [1:0]  bl,
  output logic [3:0]  cl_code,
  output logic [1:0]  al,
  output logic [2:0]  cwl,
  output logic [2:0]  tccd_l,
  output logic        wr_pre,
  output logic        rd_pre,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam logic [GAP_W-1:0] T_XPR_G = GAP_W'(tXPR);
  localparam logic [GAP_W-1:0] T_MRD_G = GAP_W'(tMRD);
  localparam logic [GAP_W-1:0] T_MOD_G = GAP_W'(tMOD);
  localparam logic [GAP_W-1:0] T_ZQ_G  = GAP_W'(tZQ);

  state_e           state_q, state_d;
  cmd_e             cmd;
  logic             cke_q, cke_rise, cke_fall;
  logic [GAP_W-1:0] gap;
  logic [13:0]      mr_q [8];
  logic [6:0]       mr_mask_q, mask_nxt, mr_bit;
  logic             mr_wr_q, init_done_q, err_q;
  logic [2:0]       mr_sel_q;
  err_e             err_code_q, err_code_d;
  logic [6:1]       err_vec;
  logic             mrs_ok, accept, order_bad;

  assign cmd      = decode_cmd(CKE, CS_n, ACT_n, RAS_n, CAS_n, WE_n, A[10]);
  assign cke_rise = CKE & ~cke_q;
  assign cke_fall = ~CKE & cke_q;
  assign mr_bit   = 7'b1 << BG0_BA;  // MR7 shifts out and never counts toward completion
  assign mask_nxt = mr_mask_q | mr_bit;

  init_gap_cnt #(.W(GAP_W)) u_gap (
    .clk_i  (CK_t),
    .rst_ni (reset_n),
    .clr_i  (cke_rise || cmd == CMD_MRS || cmd == CMD_ZQCL),
    .cnt_o  (gap)
  );

`ifdef INIT_ORDER_CHECK_EN
  logic [2:0] seq_idx_q;

  assign order_bad = (seq_idx_q == 3'd7) || (BG0_BA != MR_SEQ[seq_idx_q]);

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n)                        seq_idx_q <= '0;
    else if (accept && state_q != S_DONE) seq_idx_q <= seq_idx_q + 3'd1;
  end
`else
  assign order_bad = 1'b0;
`endif

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    err_vec = '0;
    mrs_ok  = 1'b0;
    if (state_q != S_DONE && state_q != S_ERR) begin
      if (cke_fall)          err_vec[6] = 1'b1;
      if (cmd == CMD_OTHER)  err_vec[5] = 1'b1;
      unique case (state_q)
        S_RST: begin
          if (CKE)               state_d    = S_XPR;
          if (cmd == CMD_MRS)    err_vec[1] = 1'b1;
          if (cmd == CMD_ZQCL)   err_vec[3] = 1'b1;
        end
        S_XPR: begin
          if (cmd == CMD_MRS) begin
            if (gap < T_XPR_G) err_vec[1] = 1'b1;
            if (order_bad)     err_vec[3] = 1'b1;
            mrs_ok  = 1'b1;
            state_d = S_MRS;
          end
          if (cmd == CMD_ZQCL)   err_vec[3] = 1'b1;
        end
        S_MRS: begin
          if (cmd == CMD_MRS) begin
            if (gap < T_MRD_G) err_vec[2] = 1'b1;
            if (order_bad)     err_vec[3] = 1'b1;
            mrs_ok = 1'b1;
            if (&mask_nxt)     state_d = S_MOD;
          end
          if (cmd == CMD_ZQCL)   err_vec[3] = 1'b1;
        end
        S_MOD: begin
          if (cmd == CMD_MRS) begin
            if (gap < T_MRD_G) err_vec[2] = 1'b1;
            if (order_bad)     err_vec[3] = 1'b1;
            mrs_ok = 1'b1;
          end
          if (cmd == CMD_ZQCL) begin
            if (gap < T_MOD_G) err_vec[4] = 1'b1;
            else               state_d    = S_ZQ;
          end
        end
        S_ZQ: begin
          if (cmd != CMD_DES)     err_vec[5] = 1'b1;
          else if (gap >= T_ZQ_G) state_d    = S_DONE;
        end
        default: ;
      endcase
      if (|err_vec) state_d = S_ERR;
    end

    // Scan high to low so the lowest simultaneous cause wins.
    err_code_d = ERR_NONE;
    for (int i = 6; i >= 1; i--) begin
      if (err_vec[i]) err_code_d = err_e'(3'(i));
    end

    accept = (state_q == S_DONE) ? (cmd == CMD_MRS) : (mrs_ok && !(|err_vec));
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RST;
      cke_q       <= 1'b0;
      mr_mask_q   <= '0;
      mr_wr_q     <= 1'b0;
      mr_sel_q    <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      // NOTE: the MR array is reset because the decoded outputs read it directly and must come up 0.
      for (int i = 0; i < 8; i++) mr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cke_q       <= CKE;
      mr_wr_q     <= accept;
      init_done_q <= (state_d == S_DONE);
      if (accept) begin
        mr_q[BG0_BA] <= A;
        mr_sel_q     <= BG0_BA;
        mr_mask_q    <= mask_nxt;
      end
      if (|err_vec) begin
        err_q      <= 1'b1;
        err_code_q <= err_code_d;
      end
    end
  end

  assign init_done = init_done_q;
  assign mr_wr     = mr_wr_q;
  assign mr_sel    = mr_sel_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

  assign bl      = mr_q[0][1:0];
  assign cl_code = {mr_q[0][6:4], mr_q[0][2]};
  assign al      = mr_q[1][4:3];
  assign cwl     = mr_q[2][5:3];
  assign tccd_l  = mr_q[6][12:10];
  assign wr_pre  = mr_q[4][12];
  assign rd_pre  = mr_q[4][11];

endmodule
